data_memory_ctrl: RTL

Parametrised single-port data memory with a valid/ready request interface, byte-lane write enables, a configurable pipelined read latency and a hardware clear engine. It is the next-generation data memory for the gpp_txrx processor and replaces the bare clocked RAM. Its handshake lets the load/store unit, and later the photonic network interface, stall against it cleanly. After reset, or on command, it zeroes its full contents before accepting traffic.

---
 rtl/data_memory_ctrl_if.sv | 29 ++
 rtl/data_memory_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a requester (load/store unit, network interface)
// and data_memory_ctrl. The memory side uses the slave modport.
interface data_memory_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  clear_start;
    logic                  busy;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, clear_start,
        input  req_ready, busy, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, clear_start,
        output req_ready, busy, resp_valid, resp_rdata
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready requests, byte-lane writes, a
// READ_LATENCY-deep read pipeline and a clear engine that zeroes the array.
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_clr_we;
    logic                  w_accept;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_vld [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [READ_LATENCY];

    assign w_accept    = bus.req_valid && w_ready;
    assign w_wr_accept = w_accept && bus.req_write;
    assign w_rd_accept = w_accept && !bus.req_write;

    assign bus.req_ready  = w_ready;
    assign bus.busy       = w_busy;
    assign bus.resp_valid = r_vld[READ_LATENCY-1];
    assign bus.resp_rdata = r_dat[READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A clear_start in IDLE beats any request presented in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy    = 1'b1;
                w_clr_we  = 1'b1;
                w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
                if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_ready = !bus.clear_start;
                if (bus.clear_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // The array itself is never reset; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_accept) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (bus.req_be[i]) begin
                    r_mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Data stages load only behind a valid, so the output holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_accept;
            if (w_rd_accept) begin
                r_dat[0] <= r_mem[bus.req_addr];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end
endmodule
